// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: sequencer types, micro-step table and table-size helpers
package micro_sequencer_pkg;
  typedef enum logic [1:0] {SEQ_RST, SEQ_FETCH, SEQ_EXEC, SEQ_HALT} seq_state_t;
  typedef enum logic [1:0] {ADDR_NONE, ADDR_PC, ADDR_HL, ADDR_SP} addr_sel_t;
  typedef enum logic [2:0] {CTL_NOP, CTL_HALT, CTL_LD_R8_D8, CTL_LD_HL_R8, CTL_JR_CC} ctl_op_t;
  typedef struct packed {
    addr_sel_t addr_sel;
    logic      inc_pc;
    logic      mem_to_r8;
    logic      r8_to_mem;
    logic      cond_chk;
  } micro_t;
  localparam micro_t M_IDLE = '{ADDR_NONE, 1'b0, 1'b0, 1'b0, 1'b0};
  function automatic int unsigned seq_len(input ctl_op_t op);
    case (op)
      CTL_LD_R8_D8, CTL_LD_HL_R8: return 1;
      CTL_JR_CC: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic micro_t seq_step(input ctl_op_t op, input int unsigned idx);
    micro_t m = M_IDLE;
    case (op)
      CTL_LD_R8_D8: if (idx == 0) m = '{ADDR_PC, 1'b1, 1'b1, 1'b0, 1'b0};
      CTL_LD_HL_R8: if (idx == 0) m = '{ADDR_HL, 1'b0, 1'b0, 1'b1, 1'b0};
      CTL_JR_CC: if (idx == 0) m = '{ADDR_PC, 1'b1, 1'b0, 1'b0, 1'b1};
      default: m = M_IDLE;
    endcase
    return m;
  endfunction
  function automatic int unsigned max_seq_len();
    int unsigned mx = 0;
    for (int i = 0; i < 8; i++)
      if (seq_len(ctl_op_t'(3'(i))) > mx) mx = seq_len(ctl_op_t'(3'(i)));
    return mx;
  endfunction
endpackage

// File: rtl/micro_sequencer_seq_rom.sv
// micro_sequencer_seq_rom: combinational lookup of op length and current micro-step
module micro_sequencer_seq_rom
  import micro_sequencer_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  ctl_op_t          op,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W:0]   len,
  output micro_t           step
);
  assign len  = (IDX_W + 1)'(seq_len(op));
  assign step = seq_step(op, 32'(idx));
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: table-driven M-cycle sequencer with stall hold, early exit and HALT
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter  int MAX_STEPS = 6,
  localparam int IDX_W     = $clog2(MAX_STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ctl_op_t          ctl_op,
  input  logic             mem_wait,
  input  logic             cond_met,
  input  logic             irq_pending,
  output addr_sel_t        addr_sel,
  output logic             inc_pc,
  output logic             fetch_cycle,
  output logic             mem_to_r8,
  output logic             r8_to_mem,
  output logic [IDX_W-1:0] step_idx,
  output logic             halted
);
  if (MAX_STEPS < 2) begin : g_min_steps
    $error("micro_sequencer: MAX_STEPS must be >= 2");
  end
  if (max_seq_len() > MAX_STEPS) begin : g_table_fit
    $error("micro_sequencer: a micro-sequence is longer than MAX_STEPS");
  end
  seq_state_t       state, nxt_state;
  ctl_op_t          op_q, nxt_op;
  logic [IDX_W-1:0] step_q, nxt_step;
  logic [IDX_W:0]   len;
  micro_t           m;
  logic             adv, done;
  assign adv = !mem_wait;
  micro_sequencer_seq_rom #(.IDX_W(IDX_W)) u_rom (
    .op  (state == SEQ_FETCH ? ctl_op : op_q),
    .idx (step_q),
    .len (len),
    .step(m)
  );
  assign done = ({1'b0, step_q} == len - 1'b1) || (step_q == IDX_W'(MAX_STEPS - 1))
             || (m.cond_chk && !cond_met);
  assign step_idx = state == SEQ_EXEC ? step_q : '0;
  // state register; reset abandons any op in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= SEQ_RST;
      op_q   <= CTL_NOP;
      step_q <= '0;
    end else begin
      state  <= nxt_state;
      op_q   <= nxt_op;
      step_q <= nxt_step;
    end
  // next state and per-cycle bus/datapath strobes; stalls freeze everything
  always_comb begin
    nxt_state   = state;
    nxt_op      = op_q;
    nxt_step    = step_q;
    addr_sel    = ADDR_NONE;
    inc_pc      = 1'b0;
    fetch_cycle = 1'b0;
    mem_to_r8   = 1'b0;
    r8_to_mem   = 1'b0;
    halted      = 1'b0;
    case (state)
      SEQ_RST: nxt_state = SEQ_FETCH;
      SEQ_FETCH: begin
        fetch_cycle = 1'b1;
        addr_sel    = ADDR_PC;
        inc_pc      = adv;
        if (adv) begin
          nxt_op    = ctl_op;
          nxt_step  = '0;
          nxt_state = ctl_op == CTL_HALT ? SEQ_HALT : len == '0 ? SEQ_FETCH : SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        addr_sel  = m.addr_sel;
        r8_to_mem = m.r8_to_mem;
        inc_pc    = m.inc_pc & adv;
        mem_to_r8 = m.mem_to_r8 & adv;
        if (adv) begin
          nxt_step  = done ? '0 : step_q + 1'b1;
          nxt_state = done ? SEQ_FETCH : SEQ_EXEC;
        end
      end
      SEQ_HALT: begin
        halted = 1'b1;
        if (irq_pending) nxt_state = SEQ_FETCH;
      end
      default: nxt_state = SEQ_RST;
    endcase
  end
endmodule
